param_mux_seq: RTL and testbench
================================

PARAM_MUX_SEQ -- requirements
Module: param_mux_seq

Interface
REQ-001 SHALL have parameter W, default 8, meaning data width per channel (1..32).
REQ-002 SHALL have parameter N, default 8, meaning channel count (2..16); SW = $clog2(N).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port din  input  N*W  packed channels; channel k occupies bits [k*W+W-1:k*W].
REQ-006 SHALL have port sel  input  SW  channel select, direct mode.
REQ-007 SHALL have port mode  input  1  0 = direct, 1 = scan; sampled only on start acceptance.
REQ-008 SHALL have port start  input  1  request pulse; accepted only while busy = 0.
REQ-009 SHALL have port out_ready  input  1  downstream ready.
REQ-010 SHALL have port out_valid  output  1  out_data/out_ch valid.
REQ-011 SHALL have port out_data  output  W  selected channel data, registered.
REQ-012 SHALL have port out_ch  output  SW  index of the channel in out_data.
REQ-013 SHALL have port out_err  output  1  direct-mode sel >= N flag, qualified by out_valid.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE and EMIT; IDLE->EMIT on start; EMIT->IDLE on final handshake.
REQ-016 SHALL, on start acceptance, latch mode, capture the first channel into out_data/out_ch, and assert out_valid on the next edge (1-cycle latency).
REQ-017 SHALL complete a handshake when out_valid & out_ready are high on a rising edge; out_data/out_ch SHALL stay stable while out_valid & !out_ready.
REQ-018 Direct mode SHALL emit exactly one beat, channel sel; sel >= N SHALL give out_data = 0, out_ch = sel, out_err = 1.
REQ-019 Scan mode SHALL emit channels 0..N-1 in ascending order, one per handshake; each beat SHALL capture din on the handshake edge for the next channel (no bubble when out_ready stays high).
REQ-020 Scan mode SHALL return to IDLE on the handshake of channel N-1 (wrap point); out_valid SHALL fall on that same edge.
REQ-021 start SHALL be ignored while busy = 1, including on the final-handshake edge; a new start is accepted at the earliest on the following cycle.
REQ-022 out_err SHALL be 0 in scan mode.
REQ-023 din changes after capture SHALL NOT affect a held beat.

Reset
REQ-024 SHALL, on rst_n low, immediately force state IDLE, out_valid = 0, out_data = 0, out_ch = 0, out_err = 0, busy = 0 and scan counter = 0, including mid-scan.
REQ-025 SHALL resume operation on the first rising clk edge after rst_n deasserts; no beat of an aborted scan is ever emitted.

Configuration
REQ-026 Macro PARAM_MUX_SEQ_MASK_EN, when defined, SHALL add input ch_mask [N-1:0], sampled on start acceptance; scan SHALL emit only enabled channels in ascending order and end after the highest enabled channel.
REQ-027 With the macro, start in scan mode with all mask bits zero SHALL be ignored; a direct-mode sel of a masked-off channel SHALL set out_err = 1 and out_data = 0.
REQ-028 Without the macro, the ch_mask port SHALL NOT exist and all N channels SHALL be scanned.

Structure
REQ-029 The state encoding typedef (IDLE, EMIT) and the mode constants (MODE_DIRECT = 0, MODE_SCAN = 1) SHALL reside in package param_mux_seq_pkg.
REQ-030 The combinational channel selector SHALL be a sub-module mux_n_sel (parameters W and N; inputs din and idx; output data, which is 0 for idx >= N).

Verification
REQ-031 Direct: N=8, W=8, din ch5 = 8'hA5, sel = 5, start -> next cycle out_valid = 1, out_data = A5, out_ch = 5, out_err = 0; one handshake -> busy = 0.
REQ-032 Backpressure scan: out_ready = 0 for 3 cycles with din changing -> beat 0 held stable; then out_ready = 1 -> channels 0..7 on 8 consecutive cycles, then IDLE.
REQ-033 Error: N=6, sel = 7 -> out_err = 1, out_data = 0, out_ch = 7.
REQ-034 Reset mid-scan: rst_n low after beat 3 -> all outputs 0 asynchronously; a new start after release scans from channel 0.
REQ-035 Start while busy: start pulses during a scan and on the final-handshake edge -> ignored, exactly N beats emitted.
REQ-036 Mask (macro defined): ch_mask = 8'b1010_0100 -> beats 2, 5, 7 only; ch_mask = 0 -> start ignored.

Source files
------------

// File: rtl/param_mux_seq_pkg.sv
// param_mux_seq_pkg: FSM state type and mode constants shared by param_mux_seq.
package param_mux_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/param_mux_seq_mux.sv
// mux_n_sel: combinational N-way channel selector; data is 0 for idx >= N.
module mux_n_sel #(
    parameter  int W  = 8,
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic [N*W-1:0] din,
    input  logic [SW-1:0]  idx,
    output logic [W-1:0]   data
);

    always_comb begin
        data = '0;
        for (int k = 0; k < N; k++) data = (int'(idx) == k) ? din[k*W +: W] : data;
    end

endmodule

// File: rtl/param_mux_seq.sv
// param_mux_seq: registered channel mux with direct (one beat) and scan (all channels) modes.
// Define PARAM_MUX_SEQ_MASK_EN to add ch_mask, restricting scan and direct selection to enabled channels.
module param_mux_seq
    import param_mux_seq_pkg::*;
#(
    parameter  int W  = 8,
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef PARAM_MUX_SEQ_MASK_EN
    input  logic [N-1:0]   ch_mask,
`endif
    input  logic [N*W-1:0] din,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    input  logic           start,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_err,
    output logic           busy
);

    state_t         state_q, state_d;
    logic           mode_q, mode_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [SW-1:0]  out_ch_q, out_ch_d;
    logic           out_err_q, out_err_d;
    logic [N-1:0]   mask_in, mask_cur;
    logic [SW:0]    first_en, next_en;
    logic [SW-1:0]  idx;
    logic [W-1:0]   mux_data;
    logic           accept, hs, last, sel_bad;

`ifdef PARAM_MUX_SEQ_MASK_EN
    logic [N-1:0]   mask_q, mask_d;

    assign mask_in  = ch_mask;
    assign mask_cur = mask_q;
    assign mask_d   = accept ? ch_mask : mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= '0;
        else        mask_q <= mask_d;
    end
`else
    assign mask_in  = '1;
    assign mask_cur = '1;
`endif

    // Returns {found, index} of the lowest enabled channel at or above lo.
    function automatic logic [SW:0] find_en(input logic [N-1:0] m, input int lo);
        find_en = '0;
        for (int k = N - 1; k >= 0; k--) if (k >= lo && m[k]) find_en = {1'b1, SW'(k)};
    endfunction

    always_comb begin
        first_en = find_en(mask_in, 0);
        next_en  = find_en(mask_cur, int'(out_ch_q) + 1);
        sel_bad  = (int'(sel) >= N) || !mask_in[sel];
        accept   = (state_q == IDLE) && start && (mode == MODE_DIRECT || first_en[SW]);
        hs       = (state_q == EMIT) && out_ready;
        last     = (mode_q == MODE_DIRECT) || !next_en[SW];
        idx      = (state_q == IDLE) ? ((mode == MODE_SCAN) ? first_en[SW-1:0] : sel) : next_en[SW-1:0];
    end

    mux_n_sel #(
        .W (W),
        .N (N)
    ) u_mux (
        .din  (din),
        .idx  (idx),
        .data (mux_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = accept ? EMIT : (hs && last) ? IDLE : state_q;
    end

    always_comb begin
        busy      = (state_q != IDLE);
        out_valid = (state_q == EMIT);
    end

    // The next scan channel is captured on the handshake edge, so a held beat never sees later din.
    always_comb begin
        mode_d     = accept ? mode : mode_q;
        out_ch_d   = (accept || (hs && !last)) ? idx : out_ch_q;
        out_err_d  = accept ? (mode == MODE_DIRECT && sel_bad) : out_err_q;
        out_data_d = accept ? ((mode == MODE_DIRECT && sel_bad) ? '0 : mux_data)
                   : (hs && !last) ? mux_data : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_DIRECT;
            out_data_q <= '0;
            out_ch_q   <= '0;
            out_err_q  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            out_err_q  <= out_err_d;
        end
    end

    assign out_data = out_data_q;
    assign out_ch   = out_ch_q;
    assign out_err  = out_err_q;

endmodule

// File: tb/tb_param_mux_seq.sv
// tb_param_mux_seq: scoreboard bench for param_mux_seq (N=8 instance a, N=6 instance b).
module tb_param_mux_seq;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int NB = 6;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] ch;
        logic       err;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*W-1:0]  din_a = '0;
    logic [NB*W-1:0] din_b = '0;
    logic [2:0]      sel_a = '0, sel_b = '0;
    logic            mode = 1'b0, start_a = 1'b0, start_b = 1'b0, out_ready = 1'b1;
    logic            a_valid, a_err, a_busy, b_valid, b_err, b_busy;
    logic [7:0]      a_data, b_data;
    logic [2:0]      a_ch, b_ch;
`ifdef PARAM_MUX_SEQ_MASK_EN
    logic [N-1:0]    mask_a = '1;
    logic [NB-1:0]   mask_b = '1;
`endif

    beat_t qa[$];
    beat_t qb[$];
    int checks = 0, errors = 0, beats_a = 0, beats_b = 0;

    always #5 clk = ~clk;

    param_mux_seq #(.W(W), .N(N)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef PARAM_MUX_SEQ_MASK_EN
        .ch_mask   (mask_a),
`endif
        .din       (din_a),
        .sel       (sel_a),
        .mode      (mode),
        .start     (start_a),
        .out_ready (out_ready),
        .out_valid (a_valid),
        .out_data  (a_data),
        .out_ch    (a_ch),
        .out_err   (a_err),
        .busy      (a_busy)
    );

    param_mux_seq #(.W(W), .N(NB)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef PARAM_MUX_SEQ_MASK_EN
        .ch_mask   (mask_b),
`endif
        .din       (din_b),
        .sel       (sel_b),
        .mode      (mode),
        .start     (start_b),
        .out_ready (out_ready),
        .out_valid (b_valid),
        .out_data  (b_data),
        .out_ch    (b_ch),
        .out_err   (b_err),
        .busy      (b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] d, input logic [2:0] ch, input logic err);
        mk = {d, ch, err};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_a(input logic [7:0] base);
        for (int k = 0; k < N; k++) din_a[k*W +: W] = base + 8'(k);
    endtask

    // Monitor: every handshake pops one expected beat per instance.
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (rst_n && a_valid && out_ready) begin
            if (qa.size() == 0) chk("a_unexpected_beat", {a_data, a_ch, a_err}, 32'hFFFF_FFFF);
            else begin
                e = qa.pop_front();
                chk("a_data", a_data, e.d);
                chk("a_ch", a_ch, e.ch);
                chk("a_err", a_err, e.err);
            end
            beats_a++;
        end
        if (rst_n && b_valid && out_ready) begin
            if (qb.size() == 0) chk("b_unexpected_beat", {b_data, b_ch, b_err}, 32'hFFFF_FFFF);
            else begin
                e = qb.pop_front();
                chk("b_data", b_data, e.d);
                chk("b_ch", b_ch, e.ch);
                chk("b_err", b_err, e.err);
            end
            beats_b++;
        end
    end

    initial begin
        int b0;
        tick(2);
        chk("rst_valid", a_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_data", a_data, 0);
        chk("rst_ch", a_ch, 0);
        chk("rst_err", a_err, 0);
        rst_n = 1'b1;
        tick();

        set_a(8'h10);
        din_a[5*W +: W] = 8'hA5;
        mode = 1'b0;
        sel_a = 3'd5;
        start_a = 1'b1;
        qa.push_back(mk(8'hA5, 3'd5, 1'b0));
        tick();
        start_a = 1'b0;
        chk("direct_valid", a_valid, 1);
        chk("direct_busy", a_busy, 1);
        tick();
        chk("direct_done_busy", a_busy, 0);
        sel_a = 3'd0;
        start_a = 1'b1;
        qa.push_back(mk(8'h10, 3'd0, 1'b0));
        tick();
        start_a = 1'b0;
        tick();
        sel_a = 3'd7;
        start_a = 1'b1;
        qa.push_back(mk(8'h17, 3'd7, 1'b0));
        tick();
        start_a = 1'b0;
        tick();

        set_a(8'h20);
        out_ready = 1'b0;
        mode = 1'b1;
        start_a = 1'b1;
        qa.push_back(mk(8'h20, 3'd0, 1'b0));
        for (int k = 1; k < N; k++) qa.push_back(mk(8'h40 + 8'(k), 3'(k), 1'b0));
        tick();
        start_a = 1'b0;
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_a(8'hC0 + 8'(i * 8));
            tick();
            chk("hold_valid", a_valid, 1);
            chk("hold_data", a_data, 8'h20);
            chk("hold_ch", a_ch, 0);
        end
        set_a(8'h40);
        out_ready = 1'b1;
        b0 = beats_a;
        tick(8);
        chk("scan_beats", beats_a - b0, 8);
        chk("scan_idle", a_busy, 0);

        for (int k = 0; k < NB; k++) din_b[k*W +: W] = 8'h60 + 8'(k);
        mode = 1'b0;
        sel_b = 3'd7;
        start_b = 1'b1;
        qb.push_back(mk(8'h00, 3'd7, 1'b1));
        tick();
        start_b = 1'b0;
        chk("err_flag", b_err, 1);
        tick();
        sel_b = 3'd6;
        start_b = 1'b1;
        qb.push_back(mk(8'h00, 3'd6, 1'b1));
        tick();
        start_b = 1'b0;
        tick();
        sel_b = 3'd5;
        start_b = 1'b1;
        qb.push_back(mk(8'h65, 3'd5, 1'b0));
        tick();
        start_b = 1'b0;
        tick();

        set_a(8'h50);
        mode = 1'b1;
        start_a = 1'b1;
        for (int k = 0; k < 4; k++) qa.push_back(mk(8'h50 + 8'(k), 3'(k), 1'b0));
        tick();
        start_a = 1'b0;
        tick(4);
        chk("pre_rst_ch", a_ch, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", a_valid, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_data", a_data, 0);
        chk("arst_ch", a_ch, 0);
        chk("arst_err", a_err, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        set_a(8'h70);
        start_a = 1'b1;
        for (int k = 0; k < N; k++) qa.push_back(mk(8'h70 + 8'(k), 3'(k), 1'b0));
        tick();
        start_a = 1'b0;
        chk("restart_ch", a_ch, 0);
        tick(8);
        chk("restart_idle", a_busy, 0);

        set_a(8'h80);
        start_a = 1'b1;
        for (int k = 0; k < N; k++) qa.push_back(mk(8'h80 + 8'(k), 3'(k), 1'b0));
        b0 = beats_a;
        tick(9);
        start_a = 1'b0;
        tick(3);
        chk("busy_start_beats", beats_a - b0, 8);
        chk("busy_start_idle", a_busy, 0);

`ifdef PARAM_MUX_SEQ_MASK_EN
        mask_a = 8'b1010_0100;
        set_a(8'h90);
        start_a = 1'b1;
        qa.push_back(mk(8'h92, 3'd2, 1'b0));
        qa.push_back(mk(8'h95, 3'd5, 1'b0));
        qa.push_back(mk(8'h97, 3'd7, 1'b0));
        tick();
        start_a = 1'b0;
        tick(3);
        chk("mask_idle", a_busy, 0);
        mask_a = '0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("mask_zero_ignored", a_busy, 0);
        tick(2);
        mask_a = '1;
`endif

        tick(2);
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
